// File: rtl/mac_layer_seq.sv
// mac_layer_seq: sequences one fully-connected layer through the shared
// 2-cycle pipelined S5.10 MAC.
// For each neuron j it streams N products, seeds the sum with the bias and
// converts the S10.20 sum back to S5.10 (round, saturate, optional ReLU).
// It then offers the result on a valid/ready port.
//
// Handshake: res_valid is high in OUT, and res_data/res_idx stay stable while
// res_valid is high. A transfer happens on any rising edge where
// res_valid && res_ready; res_valid drops on that same edge.
module mac_layer_seq #(
  parameter int MAX_IN    = 256,
  parameter int MAX_OUT   = 64,
  parameter int FRAC_BITS = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(MAX_IN):0]              cfg_n_in,
  input  logic [$clog2(MAX_OUT):0]             cfg_n_out,
  input  logic                                 cfg_relu,
  output logic [$clog2(MAX_IN)-1:0]            x_addr,
  input  logic [15:0]                          x_rdata,
  output logic [$clog2(MAX_IN*MAX_OUT)-1:0]    w_addr,
  input  logic [15:0]                          w_rdata,
  output logic [$clog2(MAX_OUT)-1:0]           b_addr,
  input  logic [15:0]                          b_rdata,
  output logic [15:0]                          mac_in_val,
  output logic [15:0]                          mac_weight,
  output logic [31:0]                          mac_acc_in,
  input  logic [31:0]                          mac_acc_out,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [15:0]                          res_data,
  output logic [$clog2(MAX_OUT)-1:0]           res_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           dbg_state
);

  localparam int NW = $clog2(MAX_IN) + 1;
  localparam int MW = $clog2(MAX_OUT) + 1;
  localparam int XA = $clog2(MAX_IN);
  localparam int WA = $clog2(MAX_IN*MAX_OUT);
  localparam int BA = $clog2(MAX_OUT);
  localparam logic [NW-1:0] MAX_IN_V  = NW'(MAX_IN);
  localparam logic [MW-1:0] MAX_OUT_V = MW'(MAX_OUT);
  localparam logic [32:0]   ROUND_C   = 33'(1) << (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0] n_q;
  logic [MW-1:0] m_q;
  logic          relu_q;
  logic [XA-1:0] i_q;
  logic [BA-1:0] j_q;
  logic [15:0]   bias_q;

  // Term tags: stage 1 lines up with memory data, stage 2 with mult_reg.
  logic t1_valid, t1_first, t1_last;
  logic t2_valid, t2_first, t2_last;
  // Final sum of the neuron is on mac_acc_out this cycle.
  logic sum_ready;

  logic [NW-1:0] n_clamp;
  logic [MW-1:0] m_clamp;
  logic          last_term;
  logic          last_neuron;
  logic          accept;

  logic [31:0]        bias_ext;
  logic [32:0]        rnd_sum;
  logic signed [32:0] rnd_shift;
  logic [15:0]        sat_val;
  logic [15:0]        res_next;

  assign n_clamp     = (cfg_n_in  > MAX_IN_V)  ? MAX_IN_V  : cfg_n_in;
  assign m_clamp     = (cfg_n_out > MAX_OUT_V) ? MAX_OUT_V : cfg_n_out;
  assign last_term   = ({1'b0, i_q} == (n_q - NW'(1)));
  assign last_neuron = ({1'b0, j_q} == (m_q - MW'(1)));
  assign accept      = (state_q == S_OUT) && res_ready;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign res_valid = (state_q == S_OUT);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (n_clamp == '0 || m_clamp == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_term) state_d = S_DRAIN;
      S_DRAIN: if (sum_ready) state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = last_neuron ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC operands and accumulator feed, steered by the term tags.
  always_comb begin
    bias_ext   = {{16{bias_q[15]}}, bias_q} << FRAC_BITS;
    mac_in_val = t1_valid ? x_rdata : '0;
    mac_weight = t1_valid ? w_rdata : '0;
    if (t2_first)      mac_acc_in = bias_ext;
    else if (t2_valid) mac_acc_in = mac_acc_out;
    else               mac_acc_in = '0;
  end

  // S10.20 -> S5.10: round half up, saturate, optional ReLU.
  always_comb begin
    rnd_sum   = {mac_acc_out[31], mac_acc_out} + ROUND_C;
    rnd_shift = $signed(rnd_sum) >>> FRAC_BITS;
    if (rnd_shift[32:15] == '0 || rnd_shift[32:15] == '1) sat_val = rnd_shift[15:0];
    else if (rnd_shift[32])                                sat_val = 16'h8000;
    else                                                   sat_val = 16'h7FFF;
    res_next = (relu_q && sat_val[15]) ? 16'h0000 : sat_val;
  end

  // Counters, address generation, tag pipeline and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      m_q       <= '0;
      relu_q    <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      x_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      bias_q    <= '0;
      t1_valid  <= 1'b0;
      t1_first  <= 1'b0;
      t1_last   <= 1'b0;
      t2_valid  <= 1'b0;
      t2_first  <= 1'b0;
      t2_last   <= 1'b0;
      sum_ready <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      t1_valid  <= (state_q == S_ISSUE);
      t1_first  <= (state_q == S_ISSUE) && (i_q == '0);
      t1_last   <= (state_q == S_ISSUE) && last_term;
      t2_valid  <= t1_valid;
      t2_first  <= t1_first;
      t2_last   <= t1_last;
      sum_ready <= t2_valid && t2_last;
      if (t1_first) bias_q <= b_rdata;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q    <= n_clamp;
            m_q    <= m_clamp;
            relu_q <= cfg_relu;
            i_q    <= '0;
            j_q    <= '0;
            x_addr <= '0;
            w_addr <= '0;
            b_addr <= '0;
          end
        end
        S_ISSUE: begin
          // Addresses run one term ahead; they hold on the last term so that
          // w_addr+1 is the first weight of the next row.
          if (!last_term) begin
            i_q    <= i_q + XA'(1);
            x_addr <= x_addr + XA'(1);
            w_addr <= w_addr + WA'(1);
          end else begin
            i_q <= '0;
          end
        end
        S_DRAIN: begin
          if (sum_ready) begin
            res_data <= res_next;
            res_idx  <= j_q;
          end
        end
        S_OUT: begin
          if (accept && !last_neuron) begin
            j_q    <= j_q + BA'(1);
            b_addr <= b_addr + BA'(1);
            x_addr <= '0;
            w_addr <= w_addr + WA'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_seq.sv
// tb_mac_layer_seq: directed bench for mac_layer_seq with synchronous
// layer memories and a model of the 2-cycle MAC (saturating 32-bit
// accumulator).
module tb_mac_layer_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  cfg_n_in;
  logic [6:0]  cfg_n_out;
  logic        cfg_relu;
  logic [7:0]  x_addr;
  logic [15:0] x_rdata;
  logic [13:0] w_addr;
  logic [15:0] w_rdata;
  logic [5:0]  b_addr;
  logic [15:0] b_rdata;
  logic [15:0] mac_in_val;
  logic [15:0] mac_weight;
  logic [31:0] mac_acc_in;
  logic [31:0] mac_acc_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [5:0]  res_idx;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  mac_layer_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out), .cfg_relu(cfg_relu),
    .x_addr(x_addr), .x_rdata(x_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .mac_in_val(mac_in_val), .mac_weight(mac_weight),
    .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories and MAC model ----------------
  logic [15:0] xmem [256];
  logic [15:0] wmem [16384];
  logic [15:0] bmem [64];

  always @(posedge clk) begin
    x_rdata <= xmem[x_addr];
    w_rdata <= wmem[w_addr];
    b_rdata <= bmem[b_addr];
  end

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648) return 32'h8000_0000;
    else                           return v[31:0];
  endfunction

  logic signed [31:0] mult_r;
  logic signed [31:0] acc_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_r <= '0;
      acc_r  <= '0;
    end else begin
      mult_r <= $signed(mac_in_val) * $signed(mac_weight);
      acc_r  <= sat32($signed({{32{mac_acc_in[31]}}, mac_acc_in}) + $signed({{32{mult_r[31]}}, mult_r}));
    end
  end
  assign mac_acc_out = acc_r;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total;
  int bad;
  int hold_err;
  int addr_err;
  int addr_max;
  bit addr_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Row-major weight addressing relative to the current x and b address.
  always @(negedge clk) begin
    if (addr_chk && !rst) begin
      if (32'(w_addr) != 32'(b_addr) * 3 + 32'(x_addr)) addr_err++;
      if (int'(w_addr) > addr_max) addr_max = int'(w_addr);
    end
  end

  function automatic logic [15:0] golden(input int j, input int n, input bit relu);
    longint acc;
    longint r;
    acc = longint'($signed(bmem[j])) * 1024;
    for (int i = 0; i < n; i++)
      acc = longint'(sat32(acc + longint'($signed(xmem[i])) * longint'($signed(wmem[j*n+i]))));
    r = (acc + 512) >>> 10;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_addr"},    32'(x_addr), 0);
    check({tag, "_w_addr"},    32'(w_addr), 0);
    check({tag, "_b_addr"},    32'(b_addr), 0);
    check({tag, "_mac_in"},    32'(mac_in_val), 0);
    check({tag, "_mac_w"},     32'(mac_weight), 0);
    check({tag, "_mac_acc"},   mac_acc_in, 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"},  32'(res_data), 0);
    check({tag, "_res_idx"},   32'(res_idx), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_state"},     32'(dbg_state), 0);
  endtask

  task automatic load_random(input int n, input int m, input bit relu);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom_range(0, 4095)); xmem[i] = v - 16'd2048;
    end
    for (int j = 0; j < m; j++) begin
      v = 16'($urandom_range(0, 4095)); bmem[j] = v - 16'd2048;
      for (int i = 0; i < n; i++) begin
        v = 16'($urandom_range(0, 4095)); wmem[j*n+i] = v - 16'd2048;
      end
    end
    for (int j = 0; j < m; j++) exp_q.push_back(golden(j, n, relu));
  endtask

  // Runs one layer from start to done, popping exp_q on each transfer.
  task automatic run_layer(input int n, input int m, input bit relu, input int ready_pct,
                           input bit extra_start, input int exp_cnt);
    int c, got, first_c, acc_c;
    bit stall_prev, fin;
    logic [15:0] prev_data, e;
    cfg_n_in = 9'(n); cfg_n_out = 7'(m); cfg_relu = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_n_in = 9'd5; cfg_n_out = 7'd9; cfg_relu = ~relu;
    check("busy_after_start", 32'(busy), 1);
    c = 1; got = 0; first_c = -1; acc_c = 0; stall_prev = 0; fin = 0; prev_data = '0;
    while (!fin && c < 3000) begin
      start = extra_start && (c == 3);
      if (start) cfg_n_in = 9'd0;
      res_ready = ($urandom_range(0, 99) < ready_pct);
      if (done) fin = 1;
      else begin
        if (res_valid && first_c < 0) first_c = c;
        if (stall_prev && res_valid && res_data !== prev_data) hold_err++;
        stall_prev = res_valid && !res_ready;
        prev_data  = res_data;
        if (res_valid && res_ready) begin
          check("res_idx", 32'(res_idx), 32'(got));
          if (exp_q.size() == 0) check("exp_empty", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(e));
          end
          got++;
          acc_c = c;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    res_ready = 1'b0;
    check("layer_finished", 32'(fin), 1);
    check("result_count", 32'(got), 32'(exp_cnt));
    check("done_timing", 32'(c), 32'(acc_c + 1));
    check("valid_at_done", 32'(res_valid), 0);
    if (exp_cnt > 0) check("latency", 32'(first_c), 32'(n + 4));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          n;
    bit          relu;
    logic [63:0] xs;   // x[i] in bits 16*i +: 16
    logic [63:0] ws;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int n, input bit relu, input logic [63:0] xs, input logic [63:0] ws,
                         input logic [15:0] b, input logic [15:0] e);
    vec_t v;
    v.n = n; v.relu = relu; v.xs = xs; v.ws = ws; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0; bad = 0; hold_err = 0; addr_err = 0; addr_max = 0; addr_chk = 0;
    rst = 1'b1; start = 1'b0; cfg_n_in = '0; cfg_n_out = '0; cfg_relu = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 256; i++) xmem[i] = '0;
    for (int i = 0; i < 64; i++) bmem[i] = '0;
    for (int i = 0; i < 64; i++) wmem[i] = '0;

    // 1.0*2.0 + 0.5 = 2.5
    add_vec(1, 0, 64'h0400, 64'h0800, 16'h0200, 16'h0A00);
    add_vec(4, 0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0000, 16'h7FFF);
    add_vec(4, 0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h8001_8001_8001_8001, 16'h0000, 16'h8000);
    // half LSB rounds up; minus half LSB rounds to zero
    add_vec(1, 0, 64'h0001, 64'h0200, 16'h0000, 16'h0001);
    add_vec(1, 0, 64'h0001, 64'hFE00, 16'h0000, 16'h0000);
    add_vec(1, 1, 64'h0001, 64'hFE00, 16'hFC00, 16'h0000);
    add_vec(1, 0, 64'h0001, 64'hFE00, 16'hFC00, 16'hFC00);
    // 1*1 + 1*3 + 1 = 5, ReLU leaves positives alone
    add_vec(2, 1, 64'h0400_0400, 64'h0C00_0400, 16'h0400, 16'h1400);
    // 3*(-1) + 0.5*1.5 = -2.25
    add_vec(2, 0, 64'h0200_0C00, 64'h0600_FC00, 16'h0000, 16'hF700);

    @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      for (int i = 0; i < 4; i++) begin
        xmem[i] = vecs[k].xs[16*i +: 16];
        wmem[i] = vecs[k].ws[16*i +: 16];
      end
      bmem[0] = vecs[k].b;
      exp_q.push_back(vecs[k].exp);
      run_layer(vecs[k].n, 1, vecs[k].relu, 100, 0, 1);
    end

    // N=3, M=4, random data, 30% ready duty, address pattern checked
    addr_chk = 1; addr_max = 0; addr_err = 0; hold_err = 0;
    load_random(3, 4, 0);
    run_layer(3, 4, 0, 30, 0, 4);
    addr_chk = 0;
    check("w_addr_pattern_errors", 32'(addr_err), 0);
    check("w_addr_reached_last", 32'(addr_max), 11);
    check("hold_during_stall_errors", 32'(hold_err), 0);

    // Same with ReLU
    load_random(3, 4, 1);
    run_layer(3, 4, 1, 50, 0, 4);

    // Empty layers
    run_layer(0, 3, 0, 100, 0, 0);
    run_layer(2, 0, 0, 100, 0, 0);

    // Second start while busy (with N=0) must be ignored
    load_random(2, 1, 0);
    run_layer(2, 1, 0, 100, 1, 1);

    // Reset during ISSUE of neuron 2, then a clean rerun
    begin
      int k;
      int stray;
      load_random(3, 4, 0);
      exp_q.delete();
      cfg_n_in = 9'd3; cfg_n_out = 7'd4; cfg_relu = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; res_ready = 1'b1;
      k = 0;
      while (b_addr != 6'd2 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check("reached_neuron2", 32'(k < 200), 1);
      check("neuron2_issuing", 32'(dbg_state), 1);
      rst = 1'b1; res_ready = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
        if (res_valid || done || busy) stray++;
        @(posedge clk); #1;
      end
      check("no_activity_after_reset", 32'(stray), 0);
      for (int j = 0; j < 4; j++) exp_q.push_back(golden(j, 3, 0));
      run_layer(3, 4, 0, 100, 0, 4);
    end

    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_layer_seq.md
# mac_layer_seq

Sequencer for one fully-connected layer on the team's 2-cycle pipelined S5.10 MAC. Given input count N and output count M, it reads inputs, weights and biases from synchronous ROM/RAM. It streams one product per cycle into the MAC, seeds each accumulation with the bias, then rounds, saturates and optionally ReLUs the S10.20 sum back to S5.10. Each neuron result is delivered on a valid/ready port. It sits between the layer memories and the MAC in the RL policy network datapath.

## Interface
- MAX_IN, 256: largest supported N
- MAX_OUT, 64: largest supported M
- FRAC_BITS, 10: fractional bits of the S5.10 operands
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_n_in  in  $clog2(MAX_IN)+1  N, sampled on accepted start
- cfg_n_out  in  $clog2(MAX_OUT)+1  M, sampled on accepted start
- cfg_relu  in  1  apply ReLU to results, sampled on accepted start
- x_addr  out  $clog2(MAX_IN)  input-vector read address (registered)
- x_rdata  in  16  S5.10, valid the cycle after x_addr
- w_addr  out  $clog2(MAX_IN*MAX_OUT)  weight address, row-major j*N+i (registered)
- w_rdata  in  16  S5.10, valid the cycle after w_addr
- b_addr  out  $clog2(MAX_OUT)  bias address = j (registered)
- b_rdata  in  16  S5.10, valid the cycle after b_addr
- mac_in_val, mac_weight  out  16  MAC operands; combinational pass of x_rdata/w_rdata
- mac_acc_in  out  32  MAC accumulator input, S10.20
- mac_acc_out  in  32  MAC accumulator output, S10.20
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  16  S5.10 result
- res_idx  out  $clog2(MAX_OUT)  neuron index j of res_data
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- FSM states and transitions:
  - IDLE --start--> ISSUE.
  - start with N==0 or M==0 goes to DONE instead; no reads are issued.
  - ISSUE issues term i=0..N-1 of neuron j, one per cycle, with no stalls. After i=N-1 it goes to DRAIN.
  - DRAIN holds 3 cycles, then goes to OUT.
  - OUT holds until res_valid&&res_ready. It then goes to ISSUE with j+1, or to DONE if j==M-1.
  - DONE lasts 1 cycle, pulses done, then returns to IDLE.
- A term issued in cycle k:
  - addresses are registered at the edge ending k-1 and visible during k;
  - data and MAC operands are valid in k+1;
  - the MAC mult_reg is loaded at end of k+1;
  - mac_acc_in must be correct during k+2;
  - mac_acc_out is updated at end of k+2.
- first and last flags travel with each term through a 2-stage tag pipeline.
  - mac_acc_in = sign_extend(bias) << FRAC_BITS when the tag is first; otherwise mac_acc_in = mac_acc_out.
  - bias is captured from b_rdata in the cycle after the first term's address.
  - In all other cycles mac_acc_in = 0.
- Result computation:
  - Add 2^(FRAC_BITS-1) to the final mac_acc_out, in 33-bit width.
  - Arithmetic shift right by FRAC_BITS.
  - Saturate to [-32768, 32767].
  - If relu is set, replace negatives with 0.
- The result is registered into res_data on entry to OUT.
- start in any state but IDLE is ignored. cfg_* changes after start are ignored.
- Values above MAX_* are clamped to MAX_*.

## Timing
- Reset values: all addresses 0, mac_* 0, res_valid 0, res_data 0, res_idx 0, busy 0, done 0. FSM goes to IDLE and all counters to 0.
- start accepted at edge t: busy=1 from t, first addresses visible in cycle t+1.
- Per neuron: N ISSUE cycles + 3 DRAIN cycles. res_valid rises on the edge ending the 3rd DRAIN cycle.
- Latency from start to first res_valid is N+4 cycles.
- res_valid stays high and res_data/res_idx stay stable until accepted. Acceptance drops res_valid on the same edge.
- done pulses the cycle after the final acceptance. busy falls with done.
- Reset asserted mid-layer aborts immediately. No partial result or done is produced.
- With res_ready tied high, neuron j+1 issue starts the cycle after acceptance. Throughput is N+4 cycles per neuron.

## Test plan
- N=1, M=1, x=0x0400, w=0x0800, b=0x0200 -> one result res_data=0x0A00 (2.5), res_idx=0. done one cycle after acceptance.
- N=4, M=1, all x=w=0x7FFF, b=0 -> 0x7FFF (saturated). Repeat with w=0x8001 -> 0x8000.
- N=1, x=0x0001, w=0x0200, b=0 -> 0x0001 (half rounds up). With w=0xFE00 -> 0x0000. Same with relu=1 and b=0xFC00 -> 0x0000.
- N=3, M=4, random data, res_ready random with 30% duty -> results match a golden model in order j=0..3. res_data is held during stalls. w_addr follows j*3+i.
- start with N=0 -> done pulses with no res_valid. A second start while busy is ignored.
- rst asserted in ISSUE of j=2 of M=4 -> all outputs go to reset values. A following start runs cleanly from j=0.
